// File: rtl/stoch_bitstream_decoder_if.sv
// Stochastic bitstream decoder bus: measurement handshake, bit input, result.
interface stoch_bitstream_decoder_if #(
  parameter int WINDOW_LOG2 = 8
);
  logic                   start;
  logic                   en;
  logic                   a;
  logic                   busy;
  logic                   valid;
  logic [WINDOW_LOG2:0]   count;
  logic [31:0]            estimate;

  modport master (
    output start, en, a,
    input  busy, valid, count, estimate
  );

  modport slave (
    input  start, en, a,
    output busy, valid, count, estimate
  );
endinterface

// File: rtl/stoch_bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over 2^WINDOW_LOG2 accepted bits
// and reports count plus a 32-bit fraction (2^32 == 1.0, saturated at all-ones).
// Optional macro STOCH_DEC_CONTINUOUS_EN: back-to-back windows after one start.
module stoch_bitstream_decoder #(
  parameter int WINDOW_LOG2 = 8
) (
  input logic                      CLK,
  input logic                      nRST,
  stoch_bitstream_decoder_if.slave bus
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [WINDOW_LOG2:0]   ones_q, ones_d;
  logic [WINDOW_LOG2-1:0] bits_q, bits_d;
  logic [WINDOW_LOG2:0]   count_q, count_d;
  logic [31:0]            est_q, est_d;
  logic                   valid_q, valid_d;
  logic [WINDOW_LOG2:0]   ones_nx;

  assign ones_nx = ones_q + {{WINDOW_LOG2{1'b0}}, bus.a};

  // Next-state: window start, bit acceptance, completion and result capture.
  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    bits_d  = bits_q;
    count_d = count_q;
    est_d   = est_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ACCUM;
          ones_d  = '0;
          bits_d  = '0;
        end
      end
      default: begin
        if (bus.en) begin
          if (bits_q == {WINDOW_LOG2{1'b1}}) begin
            // Last bit of the window: publish the total including this bit.
            count_d = ones_nx;
            if (ones_nx[WINDOW_LOG2])
              est_d = 32'hFFFF_FFFF;
            else
              est_d = 32'(ones_nx[WINDOW_LOG2-1:0]) << (32 - WINDOW_LOG2);
            valid_d = 1'b1;
            ones_d  = '0;
            bits_d  = '0;
`ifdef STOCH_DEC_CONTINUOUS_EN
            state_d = S_ACCUM;
`else
            state_d = S_IDLE;
`endif
          end else begin
            bits_d = bits_q + 1'b1;
            ones_d = ones_nx;
          end
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      ones_q  <= '0;
      bits_q  <= '0;
      count_q <= '0;
      est_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      bits_q  <= bits_d;
      count_q <= count_d;
      est_q   <= est_d;
      valid_q <= valid_d;
    end
  end

  assign bus.busy     = (state_q == S_ACCUM);
  assign bus.valid    = valid_q;
  assign bus.count    = count_q;
  assign bus.estimate = est_q;
endmodule

// File: tb/tb_stoch_bitstream_decoder.sv
// Bench for stoch_bitstream_decoder (WINDOW_LOG2=4) against a window-queue model.
module tb_stoch_bitstream_decoder;
  localparam int W = 4;
  localparam int N = 1 << W;

  logic CLK = 1'b0;
  logic nRST;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  stoch_bitstream_decoder_if #(.WINDOW_LOG2(W)) bif ();

  stoch_bitstream_decoder #(.WINDOW_LOG2(W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bif)
  );

  // Reference model: the current window as a queue of accepted bits.
  bit          m_busy;
  bit          m_valid;
  int          m_count;
  logic [31:0] m_est;
  bit          win[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit s, input bit e, input bit b);
    int ones;
    m_valid = 0;
    if (!r) begin
      m_busy = 0; m_count = 0; m_est = '0; win.delete();
    end else if (!m_busy) begin
      if (s) begin m_busy = 1; win.delete(); end
    end else if (e) begin
      win.push_back(b);
      if (win.size() == N) begin
        ones = 0;
        foreach (win[i]) ones += int'(win[i]);
        m_count = ones;
        m_est   = (ones == N) ? 32'hFFFF_FFFF : 32'(longint'(ones) * (64'd1 << (32 - W)));
        m_valid = 1;
        win.delete();
`ifndef STOCH_DEC_CONTINUOUS_EN
        m_busy = 0;
`endif
      end
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare #1 later.
  task automatic cyc(input bit r, input bit s, input bit e, input bit b);
    nRST = r; bif.start = s; bif.en = e; bif.a = b;
    @(posedge CLK);
    model(r, s, e, b);
    #1;
    chk("busy",     32'(bif.busy),  32'(m_busy));
    chk("valid",    32'(bif.valid), 32'(m_valid));
    chk("count",    32'(bif.count), 32'(m_count));
    chk("estimate", bif.estimate,   m_est);
  endtask

  initial begin
    nRST = 1'b0; bif.start = 1'b0; bif.en = 1'b0; bif.a = 1'b0;
    m_busy = 0; m_valid = 0; m_count = 0; m_est = '0;

    // Reset state
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 1);
    chk("rst_count_const", 32'(bif.count), 32'd0);
    chk("rst_est_const", bif.estimate, 32'd0);

    // All-ones window
    cyc(1, 1, 1, 1);
    for (int i = 0; i < N; i++) cyc(1, 0, 1, 1);
    chk("ones_count_const", 32'(bif.count), 32'd16);
    chk("ones_est_const", bif.estimate, 32'hFFFF_FFFF);
    cyc(1, 0, 0, 0);

    // Half density
    cyc(1, 1, 0, 0);
    for (int i = 0; i < N; i++) cyc(1, 0, 1, (i % 2) == 0);
    chk("half_est_const", bif.estimate, 32'h8000_0000);
    cyc(1, 0, 0, 0);

    // Three ones
    cyc(1, 1, 0, 0);
    for (int i = 0; i < N; i++) cyc(1, 0, 1, i < 3);
    chk("three_est_const", bif.estimate, 32'h3000_0000);
    cyc(1, 0, 0, 0);

    // en gaps: zeros accepted, ones offered while en=0
    cyc(1, 1, 0, 0);
    for (int i = 0; i < N; i++) begin
      if (i < 10) cyc(1, 0, 0, 1);
      cyc(1, 0, 1, 0);
    end
    chk("gap_est_const", bif.estimate, 32'd0);
    cyc(1, 0, 0, 0);

    // Reset mid-window
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < N; i++) cyc(1, 0, 1, 1);
    chk("rst_mid_count_const", 32'(bif.count), 32'd16);
    cyc(1, 0, 0, 0);

    // start held high throughout
    cyc(1, 1, 0, 0);
    for (int i = 0; i < N; i++) cyc(1, 1, 1, (i % 3) == 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);

`ifdef STOCH_DEC_CONTINUOUS_EN
    // Continuous: one start, 16 ones then 16 zeros
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 2 * N; i++) cyc(1, 0, 1, i < N);
    chk("cont_busy_const", 32'(bif.busy), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stoch_bitstream_decoder.md
Name: stoch_bitstream_decoder

Overview:
- Receive-side counterpart of the stochastic bitstream generator.
- Accumulates a unipolar stochastic bitstream over a fixed window of 2^WINDOW_LOG2 accepted bits.
- Reports the measured probability as a 32-bit unsigned fraction on the same scale as a generator MEAN, where 2^32 represents 1.0.
- Used in testbenches and on-chip monitors to recover values from stochastic datapaths.

Parameters:
- WINDOW_LOG2, default 8: log2 of window length in accepted bits. Legal range 1..31.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- nRST  input  1  reset, synchronous, active-low.
- start  input  1  request a new measurement window; sampled only in IDLE.
- en  input  1  bit-valid qualifier for a.
- a  input  1  stochastic bitstream input.
- busy  output  1  high while in ACCUM.
- valid  output  1  one-cycle pulse when a result is registered.
- count  output  WINDOW_LOG2+1  number of ones in the completed window.
- estimate  output  32  scaled probability of the completed window.

Behaviour:
- Reset (nRST low at a rising edge):
  - state=IDLE, busy=0, valid=0, count=0, estimate=0.
  - Internal ones counter and bit counter cleared.
  - Reset overrides every other input, including mid-window; a partial window is discarded with no valid pulse.
- States: IDLE, ACCUM.
- IDLE:
  - busy=0.
  - start=1 at an edge -> ACCUM, with ones counter and bit counter cleared.
  - The bit on a in the start cycle is not sampled.
- ACCUM:
  - busy=1. start is ignored; a window is never restarted by start.
  - A bit is accepted only at an edge with en=1. Then bit counter += 1 and ones counter += a.
  - With en=0, no state change occurs and a is ignored.
- Completion:
  - At the edge accepting bit index 2^WINDOW_LOG2-1, the final accepted count (including that bit) is written to count.
  - At the same edge, estimate is written, valid=1, and state -> IDLE (busy=0).
  - valid is high for exactly the one cycle after that edge, then 0.
  - Latency: the result is visible in the cycle immediately after the last accepted bit.
- Arithmetic:
  - Ones counter is WINDOW_LOG2+1 bits wide, range 0..2^WINDOW_LOG2.
  - If count == 2^WINDOW_LOG2: estimate = 32'hFFFFFFFF (saturate; 1.0 is not representable).
  - Else: estimate = count << (32-WINDOW_LOG2), zero-filled low bits.
- Hold: count and estimate hold their last value until the next completion or reset.
- start on the completion edge: state is ACCUM at that edge, so start is ignored. A new window needs start=1 in a later IDLE cycle.

Optional Feature:
- Macro STOCH_DEC_CONTINUOUS_EN.
- Defined:
  - At the completion edge, state stays ACCUM and both counters reload to 0, or the ones counter reloads to 0 and the bit counter wraps.
  - The next accepted bit belongs to the new window, so no bit is lost between windows.
  - busy stays 1 after the first start. start has no effect once running; only reset returns to IDLE.
  - valid still pulses once per window.
- Not defined: single-shot behaviour as specified above.

Test Plan (WINDOW_LOG2=4 unless noted):
- All-ones window: reset, start, 16 cycles with en=1 and a=1 -> valid pulse in the cycle after the 16th bit; count=16, estimate=32'hFFFFFFFF, busy=0 afterwards.
- Half-density window: start, a=1,0,1,0... for 16 enabled bits -> count=8, estimate=32'h80000000. A window of 3 ones -> estimate=32'h30000000.
- en gaps: start, 16 accepted bits all 0 interleaved with 10 cycles of en=0 and a=1 -> count=0, estimate=0; valid appears only after the 16th accepted bit.
- Reset mid-window: start, 7 accepted ones, nRST=0 for 1 cycle -> busy=0, valid=0, count=0, estimate=0 with no pulse. Then start and 16 ones -> count=16.
- start ignored: start held high throughout ACCUM and on the completion edge -> exactly one valid after 16 accepted bits; busy=0 the cycle after.
- STOCH_DEC_CONTINUOUS_EN defined: a single start, then 32 continuous accepted bits (16 ones, then 16 zeros) -> valid pulses 16 cycles apart; first count=16, second count=0; busy stays 1.
